// File: rtl/ysyx_22050612_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22050612_pkg
// Shared definitions for the ysyx_22050612 per-instruction sequencer:
//   - state_t         : sequencer FSM state encoding
//   - DEF_RESET_PC    : default PC loaded on reset
//   - DEF_TIMEOUT     : default memory-response watchdog limit (8-bit)
//   - dnpc_misaligned : true when a next-PC is not 4-byte aligned
// ----------------------------------------------------------------------------
package ysyx_22050612_pkg;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_FETCH = 4'd1,
      S_IWAIT = 4'd2,
      S_EXEC  = 4'd3,
      S_MEM   = 4'd4,
      S_MWAIT = 4'd5,
      S_WB    = 4'd6,
      S_HALT  = 4'd7,
      S_ERR   = 4'd8
   } state_t;

   localparam logic [63:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [7:0]  DEF_TIMEOUT  = 8'd255;

   // Only the two low PC bits matter for the alignment check.
   function automatic logic dnpc_misaligned(input logic [1:0] dnpc_lo);
      return dnpc_lo != 2'b00;
   endfunction

endpackage

// File: rtl/ysyx_22050612_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// ysyx_22050612_seq_ctrl_if
// Memory-side handshake bundle between the sequencer and the IFU/LSU ports.
//   if_req_valid/if_req_ready/if_addr : instruction fetch request
//   if_rsp_valid/if_rsp_inst          : instruction fetch response
//   mem_req_valid/mem_req_ready       : data-memory request
//   mem_rsp_valid                     : data-memory response
// master = sequencer side, slave = memory side.
// ----------------------------------------------------------------------------
interface ysyx_22050612_seq_ctrl_if;

   logic        if_req_valid;
   logic        if_req_ready;
   logic [63:0] if_addr;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_inst;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_rsp_valid;

   modport master (
      output if_req_valid, if_addr, mem_req_valid,
      input  if_req_ready, if_rsp_valid, if_rsp_inst, mem_req_ready, mem_rsp_valid
   );

   modport slave (
      input  if_req_valid, if_addr, mem_req_valid,
      output if_req_ready, if_rsp_valid, if_rsp_inst, mem_req_ready, mem_rsp_valid
   );

endinterface

// File: rtl/ysyx_22050612_wdog.sv
// ----------------------------------------------------------------------------
// ysyx_22050612_wdog
// 8-bit response watchdog. Cleared when a wait begins, counts while enabled,
// and holds at TIMEOUT, where `expired` is asserted.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart count at zero (takes priority)
//   en         : count this cycle
//   expired    : count has reached TIMEOUT
// ----------------------------------------------------------------------------
module ysyx_22050612_wdog #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [7:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign expired = (cnt == TIMEOUT);

endmodule

// File: rtl/ysyx_22050612_seq_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22050612_seq_ctrl
// Multi-cycle per-instruction sequencer: fetch, hold the instruction for
// EXU/RF evaluation, optional data-memory transaction, then a single
// register-file write and PC update.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (master)    : fetch and data-memory handshakes
//   pc, inst        : architectural PC and instruction register
//   dec_*           : decoder flags for `inst`
//   exu_dnpc        : next PC from the EXU, sampled in EXEC
//   rf_wen          : one-cycle register-file write enable (WB only)
//   instret         : retired-instruction count
//   halted, err     : sticky ebreak-retired / timeout-or-misaligned flags
// ----------------------------------------------------------------------------
module ysyx_22050612_seq_ctrl
   import ysyx_22050612_pkg::*;
#(
   parameter logic [63:0] RESET_PC = DEF_RESET_PC,
   parameter logic [7:0]  TIMEOUT  = DEF_TIMEOUT
) (
   input  logic                             clk,
   input  logic                             rst_n,
   ysyx_22050612_seq_ctrl_if.master         bus,
   output logic [63:0]                      pc,
   output logic [31:0]                      inst,
   input  logic                             dec_load,
   input  logic                             dec_store,
   input  logic                             dec_rd_we,
   input  logic                             dec_ebreak,
   input  logic [63:0]                      exu_dnpc,
   output logic                             rf_wen,
   output logic [63:0]                      instret,
   output logic                             halted,
   output logic                             err
);

   state_t      state;
   logic [63:0] npc;
   logic        wd_clr;
   logic        wd_en;
   logic        wd_expired;
   logic        wb_we;

   // The watchdog restarts on the accepting edge of either request, so the
   // first wait cycle always sees a count of zero.
   assign wd_clr = ((state == S_FETCH) && bus.if_req_ready) ||
                   ((state == S_MEM)   && bus.mem_req_ready);
   assign wd_en  = (state == S_IWAIT) || (state == S_MWAIT);

   // Stores never write the register file, whatever the decoder says.
   assign wb_we  = dec_rd_we & ~dec_store;

   // The PC register doubles as the fetch address; it only moves in WB.
   assign bus.if_addr = pc;

   ysyx_22050612_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= S_IDLE;
         pc                <= RESET_PC;
         inst              <= '0;
         instret           <= '0;
         bus.if_req_valid  <= 1'b0;
         bus.mem_req_valid <= 1'b0;
         rf_wen            <= 1'b0;
         halted            <= 1'b0;
         err               <= 1'b0;
      end else begin
         rf_wen <= 1'b0;
         case (state)
            S_IDLE: begin
               state            <= S_FETCH;
               bus.if_req_valid <= 1'b1;
            end
            S_FETCH: begin
               if (bus.if_req_ready) begin
                  state            <= S_IWAIT;
                  bus.if_req_valid <= 1'b0;
               end
            end
            S_IWAIT: begin
               // A response in the expiring cycle still wins over the timeout.
               if (bus.if_rsp_valid) begin
                  inst  <= bus.if_rsp_inst;
                  state <= S_EXEC;
               end else if (wd_expired) begin
                  state <= S_ERR;
                  err   <= 1'b1;
               end
            end
            S_EXEC: begin
               if (dec_ebreak) begin
                  // ebreak retires here; there is no WB for it.
                  state   <= S_HALT;
                  halted  <= 1'b1;
                  instret <= instret + 64'd1;
               end else if (dnpc_misaligned(exu_dnpc[1:0])) begin
                  state <= S_ERR;
                  err   <= 1'b1;
               end else if (dec_load || dec_store) begin
                  state             <= S_MEM;
                  bus.mem_req_valid <= 1'b1;
               end else begin
                  state  <= S_WB;
                  rf_wen <= wb_we;
               end
            end
            S_MEM: begin
               if (bus.mem_req_ready) begin
                  state             <= S_MWAIT;
                  bus.mem_req_valid <= 1'b0;
               end
            end
            S_MWAIT: begin
               if (bus.mem_rsp_valid) begin
                  state  <= S_WB;
                  rf_wen <= wb_we;
               end else if (wd_expired) begin
                  state <= S_ERR;
                  err   <= 1'b1;
               end
            end
            S_WB: begin
               state            <= S_FETCH;
               pc               <= npc;
               instret          <= instret + 64'd1;
               bus.if_req_valid <= 1'b1;
            end
            S_HALT, S_ERR: begin
               // Terminal until reset.
            end
            default: begin
               state <= S_ERR;
               err   <= 1'b1;
            end
         endcase
      end
   end

   // Next PC is pure data captured in EXEC and consumed in WB; no reset needed.
   always_ff @(posedge clk) begin
      if (state == S_EXEC) begin
         npc <= exu_dnpc;
      end
   end

endmodule

// File: tb/tb_ysyx_22050612_seq_ctrl.sv
module tb_ysyx_22050612_seq_ctrl;

   localparam logic [63:0] P0   = 64'h0000_0000_8000_0000;
   localparam logic [63:0] P4   = 64'h0000_0000_8000_0004;
   localparam logic [63:0] P8   = 64'h0000_0000_8000_0008;
   localparam logic [63:0] PC_  = 64'h0000_0000_8000_000C;
   localparam logic [31:0] ADDI = 32'h0050_0093;
   localparam logic [31:0] LDI  = 32'h0000_3103;
   localparam logic [31:0] SDI  = 32'h0011_3023;
   localparam logic [31:0] EBRK = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] pc;
   logic [31:0] inst;
   logic        dec_load, dec_store, dec_rd_we, dec_ebreak;
   logic [63:0] exu_dnpc;
   logic        rf_wen;
   logic [63:0] instret;
   logic        halted, err;

   int total = 0;
   int bad   = 0;

   ysyx_22050612_seq_ctrl_if bus ();

   ysyx_22050612_seq_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .pc         (pc),
      .inst       (inst),
      .dec_load   (dec_load),
      .dec_store  (dec_store),
      .dec_rd_we  (dec_rd_we),
      .dec_ebreak (dec_ebreak),
      .exu_dnpc   (exu_dnpc),
      .rf_wen     (rf_wen),
      .instret    (instret),
      .halted     (halted),
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   typedef struct {
      logic        ir, iv;
      logic [31:0] ii;
      logic        ld, st, we, eb;
      logic [63:0] dn;
      logic        mr, mv;
      logic        e_ifv, e_memv, e_rfw;
      logic [63:0] e_pc;
      logic [31:0] e_inst;
      logic [63:0] e_instret;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic ir, input logic iv, input logic [31:0] ii,
                      input logic ld, input logic st, input logic we, input logic eb,
                      input logic [63:0] dn, input logic mr, input logic mv,
                      input logic ifv, input logic memv, input logic rfw,
                      input logic [63:0] pce, input logic [31:0] inse, input logic [63:0] ire);
      vec_t v;
      v.ir = ir; v.iv = iv; v.ii = ii; v.ld = ld; v.st = st; v.we = we; v.eb = eb;
      v.dn = dn; v.mr = mr; v.mv = mv;
      v.e_ifv = ifv; v.e_memv = memv; v.e_rfw = rfw;
      v.e_pc = pce; v.e_inst = inse; v.e_instret = ire;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic ir, input logic iv, input logic [31:0] ii,
                         input logic ld, input logic st, input logic we, input logic eb,
                         input logic [63:0] dn, input logic mr, input logic mv);
      bus.if_req_ready  = ir;
      bus.if_rsp_valid  = iv;
      bus.if_rsp_inst   = ii;
      dec_load          = ld;
      dec_store         = st;
      dec_rd_we         = we;
      dec_ebreak        = eb;
      exu_dnpc          = dn;
      bus.mem_req_ready = mr;
      bus.mem_rsp_valid = mv;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in IDLE, 1 time unit after a rising edge.
   task automatic do_reset();
      rst_n = 1'b0;
      set_in(0, 0, '0, 0, 0, 0, 0, '0, 0, 0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   logic any_req;

   initial begin
      // Reset state
      set_in(0, 0, '0, 0, 0, 0, 0, '0, 0, 0);
      step();
      step();
      chk("reset_state",
          {bus.if_req_valid, bus.mem_req_valid, rf_wen, halted, err, pc, inst, instret},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P0, 32'h0, 64'h0});
      rst_n = 1'b1;

      // Main table: fetch stall, addi, load with slow ready, store
      //  ir iv ii           ld st we eb dn   mr mv   ifv memv rfw pc   inst  instret
      add(0, 0, '0,          0, 0, 0, 0, '0,  0, 0,   1,  0,   0,  P0,  '0,   0);
      add(0, 1, 32'hDEADBEEF,0, 0, 0, 0, '0,  0, 0,   1,  0,   0,  P0,  '0,   0);
      add(0, 0, '0,          0, 0, 0, 0, '0,  0, 0,   1,  0,   0,  P0,  '0,   0);
      add(0, 0, '0,          0, 0, 0, 0, '0,  0, 0,   1,  0,   0,  P0,  '0,   0);
      add(1, 0, '0,          0, 0, 0, 0, '0,  0, 0,   0,  0,   0,  P0,  '0,   0);
      add(0, 1, ADDI,        0, 0, 1, 0, '0,  0, 0,   0,  0,   0,  P0,  ADDI, 0);
      add(0, 0, '0,          0, 0, 1, 0, P4,  0, 0,   0,  0,   1,  P0,  ADDI, 0);
      add(0, 0, '0,          0, 0, 1, 0, P4,  0, 0,   1,  0,   0,  P4,  ADDI, 1);
      add(1, 0, '0,          0, 0, 0, 0, '0,  0, 0,   0,  0,   0,  P4,  ADDI, 1);
      add(0, 1, LDI,         1, 0, 1, 0, '0,  0, 0,   0,  0,   0,  P4,  LDI,  1);
      add(0, 0, '0,          1, 0, 1, 0, P8,  0, 0,   0,  1,   0,  P4,  LDI,  1);
      add(0, 0, '0,          1, 0, 1, 0, P8,  0, 0,   0,  1,   0,  P4,  LDI,  1);
      add(0, 0, '0,          1, 0, 1, 0, P8,  0, 0,   0,  1,   0,  P4,  LDI,  1);
      add(0, 0, '0,          1, 0, 1, 0, P8,  1, 0,   0,  0,   0,  P4,  LDI,  1);
      add(0, 0, '0,          1, 0, 1, 0, P8,  0, 1,   0,  0,   1,  P4,  LDI,  1);
      add(0, 0, '0,          1, 0, 1, 0, P8,  0, 0,   1,  0,   0,  P8,  LDI,  2);
      add(1, 0, '0,          0, 0, 0, 0, '0,  0, 0,   0,  0,   0,  P8,  LDI,  2);
      add(0, 1, SDI,         0, 1, 1, 0, '0,  0, 0,   0,  0,   0,  P8,  SDI,  2);
      add(0, 0, '0,          0, 1, 1, 0, PC_, 0, 0,   0,  1,   0,  P8,  SDI,  2);
      add(0, 0, '0,          0, 1, 1, 0, PC_, 1, 0,   0,  0,   0,  P8,  SDI,  2);
      add(0, 0, '0,          0, 1, 1, 0, PC_, 0, 1,   0,  0,   0,  P8,  SDI,  2);
      add(0, 0, '0,          0, 1, 1, 0, PC_, 0, 0,   1,  0,   0,  PC_, SDI,  3);

      for (int i = 0; i < vt.size(); i++) begin
         set_in(vt[i].ir, vt[i].iv, vt[i].ii, vt[i].ld, vt[i].st, vt[i].we, vt[i].eb,
                vt[i].dn, vt[i].mr, vt[i].mv);
         step();
         chk($sformatf("vec%0d", i),
             {bus.if_req_valid, bus.mem_req_valid, rf_wen, pc, bus.if_addr, inst, instret, halted, err},
             {vt[i].e_ifv, vt[i].e_memv, vt[i].e_rfw, vt[i].e_pc, vt[i].e_pc, vt[i].e_inst,
              vt[i].e_instret, 1'b0, 1'b0});
      end

      // ebreak with dec_load set: halts, retires once, never requests memory
      do_reset();
      step();
      set_in(1, 0, '0, 0, 0, 0, 0, '0, 0, 0);
      step();
      set_in(0, 1, EBRK, 1, 0, 0, 1, '0, 0, 0);
      step();
      any_req = bus.mem_req_valid;
      set_in(0, 0, '0, 1, 0, 0, 1, P4, 0, 0);
      step();
      chk("ebreak_halt", {halted, err, instret, pc, bus.if_req_valid, bus.mem_req_valid},
          {1'b1, 1'b0, 64'd1, P0, 1'b0, 1'b0});
      set_in(1, 1, ADDI, 1, 0, 1, 1, P4, 1, 1);
      for (int i = 0; i < 8; i++) begin
         step();
         any_req = any_req | bus.if_req_valid | bus.mem_req_valid | rf_wen;
      end
      chk("halt_quiet", {any_req, halted, instret, pc}, {1'b0, 1'b1, 64'd1, P0});

      // Fetch timeout: no response for 256 IWAIT cycles
      do_reset();
      step();
      set_in(1, 0, '0, 0, 0, 0, 0, '0, 0, 0);
      step();
      set_in(0, 0, '0, 0, 0, 0, 0, '0, 0, 0);
      for (int i = 0; i < 255; i++) step();
      chk("tmo_before", {err, bus.if_req_valid}, {1'b0, 1'b0});
      step();
      chk("tmo_err", {err, halted, bus.if_req_valid, bus.mem_req_valid}, {1'b1, 1'b0, 1'b0, 1'b0});
      set_in(1, 1, ADDI, 1, 0, 1, 0, P4, 1, 1);
      any_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         any_req = any_req | bus.if_req_valid | bus.mem_req_valid | rf_wen;
      end
      chk("err_quiet", {any_req, err, pc, instret, inst}, {1'b0, 1'b1, P0, 64'd0, 32'h0});

      // Response in the last allowed cycle is accepted; misaligned dnpc errors
      do_reset();
      step();
      set_in(1, 0, '0, 0, 0, 0, 0, '0, 0, 0);
      step();
      set_in(0, 0, '0, 0, 0, 0, 0, '0, 0, 0);
      for (int i = 0; i < 255; i++) step();
      set_in(0, 1, ADDI, 0, 0, 1, 0, '0, 0, 0);
      step();
      chk("tmo_edge_accept", {err, inst}, {1'b0, ADDI});
      set_in(0, 0, '0, 0, 0, 1, 0, 64'h0000_0000_8000_0002, 0, 0);
      step();
      chk("misalign_err", {err, rf_wen, pc, instret}, {1'b1, 1'b0, P0, 64'd0});
      set_in(1, 0, '0, 0, 0, 1, 0, P4, 1, 1);
      any_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         any_req = any_req | bus.if_req_valid | bus.mem_req_valid | rf_wen;
      end
      chk("misalign_quiet", {any_req, err, pc}, {1'b0, 1'b1, P0});

      // Reset during MWAIT, then stale responses
      do_reset();
      step();
      set_in(1, 0, '0, 0, 0, 0, 0, '0, 0, 0);
      step();
      set_in(0, 1, LDI, 1, 0, 1, 0, '0, 0, 0);
      step();
      set_in(0, 0, '0, 1, 0, 1, 0, P4, 0, 0);
      step();
      chk("pre_rst_mem", bus.mem_req_valid, 1'b1);
      set_in(0, 0, '0, 1, 0, 1, 0, P4, 1, 0);
      step();
      set_in(0, 0, '0, 1, 0, 1, 0, P4, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst", {pc, inst, instret, bus.if_req_valid, bus.mem_req_valid, rf_wen},
          {P0, 32'h0, 64'd0, 1'b0, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_in(0, 1, SDI, 1, 0, 1, 0, P4, 0, 1);
      step();
      chk("stale_fetch", {bus.if_req_valid, rf_wen, pc, inst, instret},
          {1'b1, 1'b0, P0, 32'h0, 64'd0});
      step();
      chk("stale_hold", {bus.if_req_valid, bus.mem_req_valid, rf_wen, inst},
          {1'b1, 1'b0, 1'b0, 32'h0});
      set_in(1, 0, '0, 0, 0, 0, 0, '0, 0, 0);
      step();
      chk("refetch", {bus.if_req_valid, bus.if_addr, err}, {1'b0, P0, 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
